// File: rtl/bshift_tx_pkg.sv
// Shared definitions for the bshift_tx serial transmitter.
// The PARITY state is only reachable when BSHIFT_TX_PARITY_EN is defined.
package bshift_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Bit counter width: it must hold the values 0..count.
    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/bshift_tx_if.sv
// Load / serial-bit handshake bundle for bshift_tx.
// Load side: a word transfers on a rising edge where i_load_valid and
// o_load_ready are both high; i_load_valid and i_data are ignored otherwise.
// Serial side: o_bit is live while o_bit_valid is high, and the bit is
// consumed on an edge where i_shift_en is high; o_bit holds otherwise.
interface bshift_tx_if #(
    parameter int COUNT = 8
) ();
    logic             i_load_valid;
    logic [COUNT-1:0] i_data;
    logic             o_load_ready;
    logic             i_shift_en;
    logic             o_bit;
    logic             o_bit_valid;
    logic             o_done;

    modport master (
        output i_load_valid, i_data, i_shift_en,
        input  o_load_ready, o_bit, o_bit_valid, o_done
    );

    modport slave (
        input  i_load_valid, i_data, i_shift_en,
        output o_load_ready, o_bit, o_bit_valid, o_done
    );
endinterface

// File: rtl/bshift_tx_ctrl.sv
// Control FSM and bit counter for bshift_tx.
// With BSHIFT_TX_PARITY_EN defined the FSM inserts a PARITY state after the
// last data bit; otherwise SHIFT returns straight to IDLE.
import bshift_tx_pkg::*;

module bshift_tx_ctrl #(
    parameter int COUNT = 8
) (
    input  logic   clk,
    input  logic   i_rst_n,
    input  logic   i_sclr,
    input  logic   i_load_valid,
    input  logic   i_shift_en,
    output state_t o_state,
    output logic   o_load_fire,
    output logic   o_shift_fire,
    output logic   o_load_ready,
    output logic   o_bit_valid,
    output logic   o_done
);
    localparam int CW = cnt_width(COUNT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic          load_fire;
    logic          shift_fire;
    logic          last_data;
    logic          final_fire;

    // Next-state decode plus the strobes the datapath and counter act on.
    always_comb begin
        state_nxt  = state;
        load_fire  = 1'b0;
        shift_fire = 1'b0;
        last_data  = 1'b0;
        final_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                load_fire = i_load_valid;
                if (i_load_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_fire = i_shift_en;
                last_data  = i_shift_en && (cnt == CW'(COUNT - 1));
`ifdef BSHIFT_TX_PARITY_EN
                if (last_data) state_nxt = ST_PARITY;
`else
                final_fire = last_data;
                if (last_data) state_nxt = ST_IDLE;
`endif
            end
`ifdef BSHIFT_TX_PARITY_EN
            ST_PARITY: begin
                final_fire = i_shift_en;
                if (i_shift_en) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; the synchronous clear wins over any transition.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else if (i_sclr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit counter (0..COUNT, cleared per word) and the registered done pulse.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (i_sclr) begin
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= final_fire;
            if (load_fire) begin
                cnt <= '0;
            end else if (shift_fire) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign o_state      = state;
    assign o_load_fire  = load_fire;
    assign o_shift_fire = shift_fire;
    assign o_load_ready = (state == ST_IDLE);
    assign o_bit_valid  = (state != ST_IDLE);
    assign o_done       = done_q;

endmodule

// File: rtl/bshift_tx.sv
// bshift_tx: parallel-in, serial-out transmitter, MSB first, one bit per
// i_shift_en consume. Optional macro BSHIFT_TX_PARITY_EN appends an even
// parity bit (XOR of the word) after the data bits.
// o_state is a debug view of the control FSM.
import bshift_tx_pkg::*;

module bshift_tx #(
    parameter int COUNT = 8
) (
    input  logic  clk,
    input  logic  i_rst_n,
    input  logic  i_sclr,
    bshift_tx_if.slave bus,
    output state_t o_state
);
    logic [COUNT-1:0] shreg;
    logic             load_fire;
    logic             shift_fire;
    state_t           state;

    bshift_tx_ctrl #(
        .COUNT(COUNT)
    ) u_ctrl (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_sclr       (i_sclr),
        .i_load_valid (bus.i_load_valid),
        .i_shift_en   (bus.i_shift_en),
        .o_state      (state),
        .o_load_fire  (load_fire),
        .o_shift_fire (shift_fire),
        .o_load_ready (bus.o_load_ready),
        .o_bit_valid  (bus.o_bit_valid),
        .o_done       (bus.o_done)
    );

    // Shift register: capture on load, shift left with zero fill on consume.
    // After the last data bit it is all zeros, so o_bit reads 0 in IDLE.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg <= '0;
        end else if (i_sclr) begin
            shreg <= '0;
        end else if (load_fire) begin
            shreg <= bus.i_data;
        end else if (shift_fire) begin
            shreg <= {shreg[COUNT-2:0], 1'b0};
        end
    end

`ifdef BSHIFT_TX_PARITY_EN
    logic parity_q;

    // Parity of the word is computed once at load and held for the PARITY state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_q <= 1'b0;
        end else if (i_sclr) begin
            parity_q <= 1'b0;
        end else if (load_fire) begin
            parity_q <= ^bus.i_data;
        end
    end

    assign bus.o_bit = (state == ST_PARITY) ? parity_q : shreg[COUNT-1];
`else
    assign bus.o_bit = shreg[COUNT-1];
`endif

    assign o_state = state;

endmodule

// File: tb/tb_bshift_tx.sv
// Directed testbench for bshift_tx (COUNT=8 main instance, COUNT=2 minimum
// width instance). Parity checks compile in with BSHIFT_TX_PARITY_EN.
import bshift_tx_pkg::*;

module tb_bshift_tx;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   sclr;
    logic   sclr2;
    state_t state;
    state_t state2;
    int     total = 0;
    int     bad   = 0;

    bshift_tx_if #(.COUNT(8)) tx_if ();
    bshift_tx_if #(.COUNT(2)) tx2_if ();

    bshift_tx #(.COUNT(8)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_sclr  (sclr),
        .bus     (tx_if),
        .o_state (state)
    );

    bshift_tx #(.COUNT(2)) dut2 (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_sclr  (sclr2),
        .bus     (tx2_if),
        .o_state (state2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_if.i_load_valid  = 1'b0;
        tx_if.i_data        = '0;
        tx_if.i_shift_en    = 1'b0;
        tx2_if.i_load_valid = 1'b0;
        tx2_if.i_data       = '0;
        tx2_if.i_shift_en   = 1'b0;
        sclr  = 1'b0;
        sclr2 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #12;
        total++;
        if (tx_if.o_load_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", tx_if.o_load_ready);
        end
        total++;
        if (tx_if.o_bit_valid !== 1'b0 || tx_if.o_bit !== 1'b0) begin
            bad++; $display("FAIL reset_bit got valid=%b bit=%b exp 0,0", tx_if.o_bit_valid, tx_if.o_bit);
        end
        total++;
        if (tx_if.o_done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b exp=0", tx_if.o_done);
        end
        total++;
        if (state !== ST_IDLE || state2 !== ST_IDLE) begin
            bad++; $display("FAIL reset_state got=%0d/%0d exp=0", state, state2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        logic [7:0] w;
        w = 8'hA5;
        tx_if.i_load_valid = 1'b1;
        tx_if.i_data       = w;
        tx_if.i_shift_en   = 1'b1;
        tick();
        tx_if.i_load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (tx_if.o_bit !== w[7-k] || tx_if.o_bit_valid !== 1'b1 || tx_if.o_done !== 1'b0) begin
                bad++;
                $display("FAIL load_bit%0d got bit=%b valid=%b done=%b exp bit=%b valid=1 done=0",
                         k, tx_if.o_bit, tx_if.o_bit_valid, tx_if.o_done, w[7-k]);
            end
            tick();
        end
`ifdef BSHIFT_TX_PARITY_EN
        total++;
        if (tx_if.o_bit !== 1'b0 || tx_if.o_bit_valid !== 1'b1 || tx_if.o_done !== 1'b0) begin
            bad++; $display("FAIL load_parity got bit=%b valid=%b done=%b exp 0,1,0",
                            tx_if.o_bit, tx_if.o_bit_valid, tx_if.o_done);
        end
        tick();
`endif
        total++;
        if (tx_if.o_done !== 1'b1 || state !== ST_IDLE || tx_if.o_load_ready !== 1'b1) begin
            bad++; $display("FAIL load_done got done=%b state=%0d ready=%b exp 1,0,1",
                            tx_if.o_done, state, tx_if.o_load_ready);
        end
        tick();
        total++;
        if (tx_if.o_done !== 1'b0 || tx_if.o_bit_valid !== 1'b0) begin
            bad++; $display("FAIL load_done_pulse got done=%b valid=%b exp 0,0",
                            tx_if.o_done, tx_if.o_bit_valid);
        end
        tx_if.i_shift_en = 1'b0;
    endtask

    task automatic test_loopback();
        logic [7:0] rx;
        int         consumed;
        logic       prev_bit;
        logic       prev_en;
        logic       done_seen;
        rx        = '0;
        consumed  = 0;
        done_seen = 1'b0;
        tx_if.i_load_valid = 1'b1;
        tx_if.i_data       = 8'h3C;
        tx_if.i_shift_en   = 1'b0;
        tick();
        tx_if.i_load_valid = 1'b0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            tx_if.i_shift_en = (c % 3 == 2);
            // Receiver shift register: takes the live bit on each consumed data strobe.
            if (tx_if.i_shift_en && tx_if.o_bit_valid && consumed < 8) begin
                rx = {rx[6:0], tx_if.o_bit};
                consumed++;
            end
            prev_bit = tx_if.o_bit;
            prev_en  = tx_if.i_shift_en;
            tick();
            if (tx_if.o_done === 1'b1) done_seen = 1'b1;
            if (!prev_en) begin
                total++;
                if (tx_if.o_bit !== prev_bit) begin
                    bad++; $display("FAIL loop_hold cycle=%0d got=%b exp=%b", c, tx_if.o_bit, prev_bit);
                end
            end
        end
        tx_if.i_shift_en = 1'b0;
        total++;
        if (done_seen !== 1'b1) begin
            bad++; $display("FAIL loop_done got=%b exp=1", done_seen);
        end
        total++;
        if (consumed != 8 || rx !== 8'h3C) begin
            bad++; $display("FAIL loop_data got rx=%h consumed=%0d exp rx=3c consumed=8", rx, consumed);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'h6C;
        w2 = 8'h81;
        tx_if.i_load_valid = 1'b1;
        tx_if.i_data       = w1;
        tx_if.i_shift_en   = 1'b1;
        tick();
        tx_if.i_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (tx_if.o_bit !== w1[7-k] || tx_if.o_load_ready !== 1'b0) begin
                bad++; $display("FAIL b2b_w1_bit%0d got bit=%b ready=%b exp bit=%b ready=0",
                                k, tx_if.o_bit, tx_if.o_load_ready, w1[7-k]);
            end
            tick();
        end
`ifdef BSHIFT_TX_PARITY_EN
        total++;
        if (tx_if.o_bit !== 1'b0 || tx_if.o_load_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_w1_parity got bit=%b ready=%b exp 0,0", tx_if.o_bit, tx_if.o_load_ready);
        end
        tick();
`endif
        total++;
        if (tx_if.o_done !== 1'b1 || tx_if.o_load_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_done got done=%b ready=%b exp 1,1", tx_if.o_done, tx_if.o_load_ready);
        end
        tx_if.i_data = w2;
        tick();
        tx_if.i_load_valid = 1'b0;
        total++;
        if (tx_if.o_done !== 1'b0 || tx_if.o_bit_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_reload got done=%b valid=%b exp 0,1", tx_if.o_done, tx_if.o_bit_valid);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (tx_if.o_bit !== w2[7-k] || tx_if.o_bit_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_w2_bit%0d got bit=%b valid=%b exp bit=%b valid=1",
                                k, tx_if.o_bit, tx_if.o_bit_valid, w2[7-k]);
            end
            tick();
        end
`ifdef BSHIFT_TX_PARITY_EN
        total++;
        if (tx_if.o_bit !== 1'b0) begin
            bad++; $display("FAIL b2b_w2_parity got=%b exp=0", tx_if.o_bit);
        end
        tick();
`endif
        total++;
        if (tx_if.o_done !== 1'b1) begin
            bad++; $display("FAIL b2b_w2_done got=%b exp=1", tx_if.o_done);
        end
        tx_if.i_shift_en = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic done_seen;
        logic valid_seen;
        // Synchronous clear after three consumed bits of 8'hF0.
        tx_if.i_load_valid = 1'b1;
        tx_if.i_data       = 8'hF0;
        tx_if.i_shift_en   = 1'b1;
        tick();
        tx_if.i_load_valid = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (tx_if.o_bit !== 1'b1 || tx_if.o_bit_valid !== 1'b1) begin
            bad++; $display("FAIL sclr_pre got bit=%b valid=%b exp 1,1", tx_if.o_bit, tx_if.o_bit_valid);
        end
        sclr = 1'b1;
        tx_if.i_load_valid = 1'b1;
        tx_if.i_data       = 8'h55;
        tick();
        sclr = 1'b0;
        tx_if.i_load_valid = 1'b0;
        total++;
        if (state !== ST_IDLE || tx_if.o_bit_valid !== 1'b0 || tx_if.o_load_ready !== 1'b1 ||
            tx_if.o_done !== 1'b0 || tx_if.o_bit !== 1'b0) begin
            bad++; $display("FAIL sclr_state got state=%0d valid=%b ready=%b done=%b bit=%b exp 0,0,1,0,0",
                            state, tx_if.o_bit_valid, tx_if.o_load_ready, tx_if.o_done, tx_if.o_bit);
        end
        done_seen  = 1'b0;
        valid_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (tx_if.o_done === 1'b1) done_seen = 1'b1;
            if (tx_if.o_bit_valid === 1'b1) valid_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0 || valid_seen !== 1'b0) begin
            bad++; $display("FAIL sclr_after got done=%b valid=%b exp 0,0", done_seen, valid_seen);
        end

        // Asynchronous reset pulse mid-word, checked before the next edge.
        tx_if.i_load_valid = 1'b1;
        tx_if.i_data       = 8'hF0;
        tick();
        tx_if.i_load_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== ST_IDLE || tx_if.o_bit_valid !== 1'b0 || tx_if.o_load_ready !== 1'b1 ||
            tx_if.o_done !== 1'b0) begin
            bad++; $display("FAIL rst_state got state=%0d valid=%b ready=%b done=%b exp 0,0,1,0",
                            state, tx_if.o_bit_valid, tx_if.o_load_ready, tx_if.o_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (tx_if.o_done === 1'b1) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin
            bad++; $display("FAIL rst_after got done=%b exp=0", done_seen);
        end
        tx_if.i_shift_en = 1'b0;
        tick();
    endtask

`ifdef BSHIFT_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       par_exp [2];
        words   = '{8'h07, 8'h03};
        par_exp = '{1'b1, 1'b0};
        for (int n = 0; n < 2; n++) begin
            tx_if.i_load_valid = 1'b1;
            tx_if.i_data       = words[n];
            tx_if.i_shift_en   = 1'b1;
            tick();
            tx_if.i_load_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                total++;
                if (tx_if.o_bit !== words[n][7-k]) begin
                    bad++; $display("FAIL par_w%0d_bit%0d got=%b exp=%b", n, k, tx_if.o_bit, words[n][7-k]);
                end
                tick();
            end
            // Hold one cycle in PARITY to see the bit stay put.
            tx_if.i_shift_en = 1'b0;
            tick();
            total++;
            if (tx_if.o_bit !== par_exp[n] || tx_if.o_bit_valid !== 1'b1 || state !== ST_PARITY) begin
                bad++; $display("FAIL par_w%0d_bit got bit=%b valid=%b state=%0d exp bit=%b valid=1 state=2",
                                n, tx_if.o_bit, tx_if.o_bit_valid, state, par_exp[n]);
            end
            tx_if.i_shift_en = 1'b1;
            tick();
            total++;
            if (tx_if.o_done !== 1'b1 || state !== ST_IDLE) begin
                bad++; $display("FAIL par_w%0d_done got done=%b state=%0d exp 1,0", n, tx_if.o_done, state);
            end
            tx_if.i_shift_en = 1'b0;
            tick();
        end
    endtask
`endif

    task automatic test_min_width();
        tx2_if.i_load_valid = 1'b1;
        tx2_if.i_data       = 2'b10;
        tx2_if.i_shift_en   = 1'b1;
        tick();
        tx2_if.i_load_valid = 1'b0;
        total++;
        if (tx2_if.o_bit !== 1'b1 || tx2_if.o_bit_valid !== 1'b1) begin
            bad++; $display("FAIL min_bit0 got bit=%b valid=%b exp 1,1", tx2_if.o_bit, tx2_if.o_bit_valid);
        end
        tick();
        total++;
        if (tx2_if.o_bit !== 1'b0 || tx2_if.o_bit_valid !== 1'b1 || tx2_if.o_done !== 1'b0) begin
            bad++; $display("FAIL min_bit1 got bit=%b valid=%b done=%b exp 0,1,0",
                            tx2_if.o_bit, tx2_if.o_bit_valid, tx2_if.o_done);
        end
        tick();
`ifdef BSHIFT_TX_PARITY_EN
        total++;
        if (tx2_if.o_bit !== 1'b1 || tx2_if.o_done !== 1'b0) begin
            bad++; $display("FAIL min_parity got bit=%b done=%b exp 1,0", tx2_if.o_bit, tx2_if.o_done);
        end
        tick();
`endif
        total++;
        if (tx2_if.o_done !== 1'b1 || state2 !== ST_IDLE) begin
            bad++; $display("FAIL min_done got done=%b state=%0d exp 1,0", tx2_if.o_done, state2);
        end
        tx2_if.i_shift_en = 1'b0;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load();
        test_loopback();
        test_back_to_back();
        test_abort();
`ifdef BSHIFT_TX_PARITY_EN
        test_parity();
`endif
        test_min_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bshift_tx.md
# bshift_tx

Parallel-in, serial-out transmitter: the send-side partner of `bshift_reg`. It accepts a COUNT-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per `i_shift_en` strobe. If `bshift_reg` shifts `o_bit` in on each consumed strobe, its `o_data` equals the loaded word after COUNT strobes. It sits between a word source (FIFO or control FSM) and the serial link, with `i_shift_en` driven by a baud or bit-tick generator.

## Interface
- `COUNT`, default 8: word width in bits; must be 2 or more.
- `clk` input, 1 bit: sole clock, rising edge.
- `i_rst_n` input, 1 bit: reset.
  - One clock; reset is asynchronous and active-low.
- `i_sclr` input, 1 bit: synchronous clear (abort).
- `i_load_valid` input, 1 bit: `i_data` is valid.
- `i_data` input, COUNT bits: word to send.
- `o_load_ready` output, 1 bit: the block can accept a word.
- `i_shift_en` input, 1 bit: bit-tick strobe; the current `o_bit` is consumed in this cycle.
- `o_bit` output, 1 bit: serial data.
- `o_bit_valid` output, 1 bit: `o_bit` carries a live bit.
- `o_done` output, 1 bit: one-cycle pulse when the last bit has been consumed.

## Operation
- **States:**
  - IDLE: waiting for a word.
  - SHIFT: sending data bits.
  - PARITY: sending the parity bit (exists only with the macro).
- **Reset (`i_rst_n`=0, asynchronous):**
  - state IDLE; shift register 0; bit counter 0.
  - `o_bit`=0, `o_bit_valid`=0, `o_done`=0, `o_load_ready`=1.
- **`i_sclr`=1 at an edge:**
  - Same result as reset, but synchronous.
  - Overrides load and shift in the same cycle.
  - No `o_done` pulse is produced.
- **IDLE:**
  - `o_load_ready`=1.
  - On `i_load_valid` && `o_load_ready`: latch `i_data`, clear the counter, go to SHIFT.
  - `i_shift_en` is ignored.
- **SHIFT:**
  - `o_bit` = shift register MSB; `o_bit_valid`=1; `o_load_ready`=0.
  - On `i_shift_en`: shift left with 0 fill; counter +1.
  - The consume that brings the counter to COUNT exits SHIFT: to IDLE without the macro, to PARITY with it.
- **Strobe rules:**
  - When `i_shift_en` is low, `o_bit` holds.
  - `i_load_valid` is ignored outside IDLE; the word is not queued.
- **Counter:** width `$clog2(COUNT+1)`, counts 0 to COUNT, no wrap.
- **`o_done`:** registered. High for exactly one cycle, the cycle after the final consume, which is also the first IDLE cycle.
- **Back-to-back words:** a load accepted during the `o_done` cycle is legal. The next word's first bit then appears one cycle later.

## Timing
- **Load latency:** load accepted at edge N, so `o_bit`=`i_data[COUNT-1]` and `o_bit_valid`=1 from cycle N+1.
- **Throughput:**
  - With `i_shift_en` held high, bit k is presented in cycle N+1+k.
  - The last data bit is consumed in cycle N+COUNT.
  - `o_done` is high in cycle N+COUNT+1, plus one more cycle with the macro.
- **Output source:** all outputs are registered or decoded only from state, so there is no combinational path from any input.
- **Minimum word period:** COUNT+1 cycles, plus 1 with the macro.

## Configuration
- **`BSHIFT_TX_PARITY_EN` defined:**
  - After the last data bit, PARITY presents even parity of the latched word (XOR of all COUNT bits) with `o_bit_valid`=1.
  - One `i_shift_en` consume in PARITY moves to IDLE and pulses `o_done`.
- **Undefined:** no PARITY state, no parity logic, and SHIFT goes directly to IDLE.

## Structure
- A shared package holds:
  - the state encoding: `ST_IDLE`, `ST_SHIFT`, `ST_PARITY`;
  - the counter-width function `$clog2(COUNT+1)`.
- A single sub-module `bshift_tx_ctrl` holds the FSM and bit counter.
- The top level holds the shift register and parity XOR.

## Test plan
- **Reset and load:**
  - Stimulus: reset, then load 8'hA5 with `i_shift_en` held at 1.
  - Required: `o_bit` sequence 1,0,1,0,0,1,0,1 in cycles N+1..N+8; `o_done` high in N+9 only.
- **Loopback into `bshift_reg`:**
  - Stimulus: COUNT=8; drive `i_shift_en` every 3rd cycle and shift the receiver on each consumed strobe; send 8'h3C.
  - Required: receiver `o_data`=8'h3C after 8 consumes; `o_bit` stable between strobes.
- **Busy load and back-to-back:**
  - Stimulus: assert `i_load_valid` with 8'hFF while in SHIFT, then load 8'h81 during the `o_done` cycle.
  - Required: 8'hFF is ignored; 8'h81 is transmitted starting the next cycle.
- **Abort:**
  - Stimulus: `i_sclr` after 3 bits of 8'hF0, then a separate async `i_rst_n` pulse mid-word.
  - Required: IDLE, `o_bit_valid`=0, `o_load_ready`=1, no `o_done`, in both cases.
- **Parity (`BSHIFT_TX_PARITY_EN`):**
  - Stimulus: send 8'h07, then 8'h03.
  - Required: parity bits 1 and 0 respectively; `o_done` one cycle after the parity consume.
- **Minimum width:** COUNT=2 sends 2'b10 and produces 1,0 then `o_done`.
